// File: rtl/choose_ref_node_pkg.sv
// Shared definitions for the stage-4 "choose reference node" control: state codes,
// the per-state strobe set and default timing constants.
package choose_ref_node_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RST     = 4'd1,
    S_CHOOSE  = 4'd2,
    S_REFNODE = 4'd3,
    S_LOAD    = 4'd4,
    S_JUDGE   = 4'd5,
    S_INVALID = 4'd6,
    S_DONE    = 4'd7
  } state_t;

  localparam int unsigned DISPLAY_CYCLES_DEF  = 50_000_000;
  localparam int unsigned TIMER_W_DEF         = 26;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;

  typedef struct packed {
    logic go_reset_data;
    logic go_display_choose;
    logic go_display_refnode;
    logic ld_node_index;
    logic go_judge_valid;
    logic go_display_invalid;
    logic stage_done;
  } strobes_t;

  function automatic strobes_t decode_strobes(input state_t s);
    strobes_t o;
    o = '0;
    case (s)
      S_RST:     o.go_reset_data      = 1'b1;
      S_CHOOSE:  o.go_display_choose  = 1'b1;
      S_REFNODE: o.go_display_refnode = 1'b1;
      S_LOAD:    o.ld_node_index      = 1'b1;
      S_JUDGE:   o.go_judge_valid     = 1'b1;
      S_INVALID: o.go_display_invalid = 1'b1;
      S_DONE:    o.stage_done         = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/choose_ref_node_control_key.sv
// Confirm-key front end: 2-flop synchroniser, optional debounce (CHOOSE_REF_DEBOUNCE_EN),
// and a one-cycle pulse on each press (released -> pressed transition).
module key_press_detect #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_press
);

  logic sync1, sync2, level, level_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef CHOOSE_REF_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] stable_cnt;

  // Level follows the synchronised key only after it has disagreed for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level      <= 1'b1;
      stable_cnt <= '0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      level      <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  if (DEBOUNCE_CYCLES == 0) begin : g_debounce_unused
  end
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) level_q <= 1'b1;
    else         level_q <= level;
  end

  assign key_press = level_q & ~level;

endmodule

// File: rtl/choose_ref_node_control.sv
// Stage-4 control FSM: sequences the reference-node datapath and the operator key dialogue.
// Optional key debounce via CHOOSE_REF_DEBOUNCE_EN (see key_press_detect).
module choose_ref_node_control
  import choose_ref_node_pkg::*;
#(
  parameter int unsigned DISPLAY_CYCLES  = DISPLAY_CYCLES_DEF,
  parameter int unsigned TIMER_W         = TIMER_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_n,
  input  logic       data_reset_done,
  input  logic       done_judge,
  input  logic       node_index_valid,
  output logic       go_reset_data,
  output logic       go_display_choose,
  output logic       go_display_refnode,
  output logic       ld_node_index,
  output logic       go_judge_valid,
  output logic       go_display_invalid,
  output logic       stage_done,
  output logic [3:0] state_dbg
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DISPLAY_CYCLES - 1);

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer;
  logic                key_press;
  strobes_t            strobes;

  key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk       (clk),
    .resetn    (resetn),
    .key_n     (key_n),
    .key_press (key_press)
  );

  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && !start) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start)              state_nxt = S_RST;
        S_RST:     if (data_reset_done)    state_nxt = S_CHOOSE;
        S_CHOOSE:  if (timer == TIMER_LAST) state_nxt = S_REFNODE;
        S_REFNODE: if (key_press)          state_nxt = S_LOAD;
        S_LOAD:    if (key_press)          state_nxt = S_JUDGE;
        S_JUDGE:   if (done_judge)         state_nxt = node_index_valid ? S_DONE : S_INVALID;
        S_INVALID: if (timer == TIMER_LAST) state_nxt = S_REFNODE;
        S_DONE:                            state_nxt = S_DONE;
        default:                           state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with the state register glitch-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      timer   <= '0;
      strobes <= '0;
    end else begin
      state   <= state_nxt;
      strobes <= decode_strobes(state_nxt);
      if (state_nxt != state)
        timer <= '0;
      else if (state == S_CHOOSE || state == S_INVALID)
        timer <= timer + 1'b1;
      else
        timer <= '0;
    end
  end

  assign go_reset_data      = strobes.go_reset_data;
  assign go_display_choose  = strobes.go_display_choose;
  assign go_display_refnode = strobes.go_display_refnode;
  assign ld_node_index      = strobes.ld_node_index;
  assign go_judge_valid     = strobes.go_judge_valid;
  assign go_display_invalid = strobes.go_display_invalid;
  assign stage_done         = strobes.stage_done;
  assign state_dbg          = state;

endmodule
